// File: rtl/calc_sequencer.sv
// Operation sequencer: a CPU-visible slave that drives one arithmetic peripheral
// through the write / init / poll / read sequence, optionally chaining into BCD.
module calc_sequencer #(
    parameter int unsigned TIMEOUT   = 1024,
    parameter logic [4:0]  ADDR_A    = 5'h04,
    parameter logic [4:0]  ADDR_B    = 5'h08,
    parameter logic [4:0]  ADDR_INIT = 5'h0C,
    parameter logic [4:0]  ADDR_RES  = 5'h10,
    parameter logic [4:0]  ADDR_DONE = 5'h14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d_in,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out,
    output logic [3:0]  m_cs,
    output logic [4:0]  m_addr,
    output logic        m_rd,
    output logic        m_wr,
    output logic [31:0] m_d_out,
    input  logic [31:0] m_d_in
);

    localparam logic [4:0]  REG_OPA    = 5'h00;
    localparam logic [4:0]  REG_OPB    = 5'h04;
    localparam logic [4:0]  REG_CTRL   = 5'h08;
    localparam logic [4:0]  REG_STATUS = 5'h0C;
    localparam logic [4:0]  REG_RESULT = 5'h10;
    localparam logic [4:0]  REG_BCD    = 5'h14;
    localparam logic [1:0]  OP_SQRT    = 2'd2;
    localparam logic [1:0]  OP_BCD     = 2'd3;
    localparam logic [15:0] POLL_LIMIT = 16'(TIMEOUT);

    typedef enum logic [3:0] {
        IDLE, WR_A, WR_B, WR_INIT, POLL_RD, POLL_CHK, RD_RES, CAP, FIN, ERR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] opa_q, opa_d, opb_q, opb_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [15:0] poll_q, poll_d;
    logic [1:0]  op_q, op_d;
    logic        chain_q, chain_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [31:0] result_q, result_d, bcd_q, bcd_d, d_out_q, d_out_d;
    logic        start_acc;
    logic        unused_bits;

    assign unused_bits = ^d_in[31:16];
    assign d_out       = d_out_q;
    assign start_acc   = cs && wr && (addr == REG_CTRL) && d_in[3] && !busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            poll_q   <= '0;
            op_q     <= '0;
            chain_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            bcd_q    <= '0;
            d_out_q  <= '0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            a_q      <= a_d;
            b_q      <= b_d;
            poll_q   <= poll_d;
            op_q     <= op_d;
            chain_q  <= chain_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
            bcd_q    <= bcd_d;
            d_out_q  <= d_out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        a_d      = a_q;
        b_d      = b_q;
        poll_d   = poll_q;
        op_d     = op_q;
        chain_d  = chain_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        result_d = result_q;
        bcd_d    = bcd_q;
        d_out_d  = d_out_q;
        m_addr   = '0;
        m_rd     = 1'b0;
        m_wr     = 1'b0;
        m_d_out  = '0;
        m_cs     = (state_q == IDLE) ? 4'b0000 : (4'b0001 << op_q);

        if (cs && wr && !busy_q) begin
            if (addr == REG_OPA) opa_d = d_in[15:0];
            if (addr == REG_OPB) opb_d = d_in[15:0];
        end

        if (cs && rd) begin
            case (addr)
                REG_OPA:    d_out_d = {16'h0, opa_q};
                REG_OPB:    d_out_d = {16'h0, opb_q};
                REG_STATUS: d_out_d = {29'h0, err_q, done_q, busy_q};
                REG_RESULT: d_out_d = result_q;
                REG_BCD:    d_out_d = bcd_q;
                default:    d_out_d = '0;
            endcase
        end

        case (state_q)
            // FIN and ERR flags were already set on entry, so a start may
            // be accepted here as well as in IDLE.
            IDLE, FIN, ERR: begin
                state_d = IDLE;
                if (start_acc) begin
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    op_d    = d_in[1:0];
                    chain_d = d_in[2];
                    a_d     = opa_q;
                    b_d     = opb_q;
                    poll_d  = '0;
                    state_d = WR_A;
                end
            end
            WR_A: begin
                m_wr    = 1'b1;
                m_addr  = ADDR_A;
                m_d_out = {16'h0, a_q};
                state_d = (op_q == OP_SQRT || op_q == OP_BCD) ? WR_INIT : WR_B;
            end
            WR_B: begin
                m_wr    = 1'b1;
                m_addr  = ADDR_B;
                m_d_out = {16'h0, b_q};
                state_d = WR_INIT;
            end
            WR_INIT: begin
                m_wr    = 1'b1;
                m_addr  = ADDR_INIT;
                m_d_out = 32'd1;
                state_d = POLL_RD;
            end
            POLL_RD: begin
                m_rd    = 1'b1;
                m_addr  = ADDR_DONE;
                state_d = POLL_CHK;
            end
            POLL_CHK: begin
                if (m_d_in[0]) begin
                    state_d = RD_RES;
                end else if (poll_q == POLL_LIMIT) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ERR;
                end else begin
                    poll_d  = poll_q + 16'd1;
                    state_d = POLL_RD;
                end
            end
            RD_RES: begin
                m_rd    = 1'b1;
                m_addr  = ADDR_RES;
                state_d = CAP;
            end
            CAP: begin
                if (op_q == OP_BCD) bcd_d = m_d_in;
                else                result_d = m_d_in;
                if (chain_q && op_q != OP_BCD) begin
                    op_d    = OP_BCD;
                    a_d     = {8'h0, m_d_in[7:0]};
                    poll_d  = '0;
                    state_d = WR_A;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = FIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
